// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI read port (AR + R channels) of a RAM between two
//   requesters. A single burst is outstanding at a time; on contention the
//   requester that did not win last time gets the RAM next.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   s_arid/araddr/arlen        per-requester AR payload, requester k in slice k
//   s_arvalid, s_arready       per-requester AR handshake
//   s_rid/rdata/rlast          shared R payload towards both requesters
//   s_rvalid, s_rready         per-requester R handshake
//   m_ar*                      AR port towards the RAM (size/burst constant)
//   m_r*                       R port from the RAM
//   grant                      one-hot owner of the RAM read port, 0 when idle
//   len_err                    sticky flag: RAM rlast disagreed with arlen
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*ID_WIDTH-1:0]   s_arid,
  input  logic [2*ADDR_WIDTH-1:0] s_araddr,
  input  logic [15:0]             s_arlen,
  input  logic [1:0]              s_arvalid,
  output logic [1:0]              s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic                    s_rlast,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_rready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [1:0]              grant,
  output logic                    len_err
);

  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_winner_q, last_winner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       len_err_q, len_err_d;

  // Index of the granted requester; grant is one-hot so bit 1 is the index.
  logic sel;
  assign sel = grant_q[1];

  // AR payload mux and constant burst attributes.
  assign m_arid    = sel ? s_arid[2*ID_WIDTH-1:ID_WIDTH]       : s_arid[ID_WIDTH-1:0];
  assign m_araddr  = sel ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
  assign m_arlen   = sel ? s_arlen[15:8]                       : s_arlen[7:0];
  assign m_arsize  = ARSIZE;
  assign m_arburst = 2'b01;

  // R payload is broadcast; only the granted s_rvalid qualifies it.
  assign s_rid   = m_rid;
  assign s_rdata = m_rdata;
  assign s_rlast = m_rlast;

  assign grant   = grant_q;
  assign len_err = len_err_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    cnt_d         = cnt_q;
    len_err_d     = len_err_q;
    m_arvalid     = 1'b0;
    s_arready     = 2'b00;
    m_rready      = 1'b0;
    s_rvalid      = 2'b00;

    unique case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (|s_arvalid) begin
          state_d = ADDR;
          // On contention the previous loser wins; last_winner resets to 1
          // so requester 0 takes the first contention.
          if (s_arvalid == 2'b11) begin
            grant_d = last_winner_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = s_arvalid;
          end
        end
      end

      ADDR: begin
        m_arvalid      = 1'b1;
        s_arready[sel] = m_arready;
        if (m_arready) begin
          cnt_d         = m_arlen;
          last_winner_d = sel;
          state_d       = DATA;
        end
      end

      DATA: begin
        m_rready      = s_rready[sel];
        s_rvalid[sel] = m_rvalid;
        if (m_rvalid && s_rready[sel]) begin
          cnt_d = cnt_q - 8'd1;
          // The counter reaches zero exactly on the beat that should be last.
          if (m_rlast != (cnt_q == 8'd0)) begin
            len_err_d = 1'b1;
          end
          if (m_rlast) begin
            state_d = IDLE;
            grant_d = 2'b00;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      last_winner_q <= 1'b1;
      cnt_q         <= 8'd0;
      len_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      cnt_q         <= cnt_d;
      len_err_q     <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Directed, table-driven bench. Each table row is one clock cycle: inputs
//   are driven at the falling edge, outputs are checked 1 ns later, and the
//   rising edge then commits the cycle. Requester 0 reads 4 beats from 0x0010
//   (id A0), requester 1 reads 2 beats from 0x0200 (id B1). A few
//   hand-written sequences follow for latency and R payload routing.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_arid;
  logic [31:0] s_araddr;
  logic [15:0] s_arlen;
  logic [1:0]  s_arvalid;
  logic [1:0]  s_arready;
  logic [7:0]  s_rid;
  logic [31:0] s_rdata;
  logic        s_rlast;
  logic [1:0]  s_rvalid;
  logic [1:0]  s_rready;
  logic [7:0]  m_arid;
  logic [15:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [7:0]  m_rid;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic [1:0]  grant;
  logic        len_err;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .len_err(len_err)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic [1:0] arv;
    logic       arr;
    logic       rv;
    logic       rl;
    logic [1:0] rr;
    logic [1:0] e_grant;
    logic       e_marv;
    logic [1:0] e_sarr;
    logic [1:0] e_srv;
    logic       e_mrr;
    logic       e_lerr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t v(string n, logic r, logic [1:0] arv, logic arr,
                             logic rv, logic rl, logic [1:0] rr,
                             logic [1:0] g, logic marv, logic [1:0] sarr,
                             logic [1:0] srv, logic mrr, logic lerr);
    vec_t t;
    t.name = n; t.rst_n = r; t.arv = arv; t.arr = arr; t.rv = rv; t.rl = rl;
    t.rr = rr; t.e_grant = g; t.e_marv = marv; t.e_sarr = sarr;
    t.e_srv = srv; t.e_mrr = mrr; t.e_lerr = lerr;
    return t;
  endfunction

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  task automatic fill_table();
    //            name          rst arv  arr rv rl rr     grant marv sarr   srv    mrr lerr
    // single request from r0
    vecs.push_back(v("rst",       0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("idle",      1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("req0",      1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("addr_wait", 1, 2'b01, 0, 0, 0, 2'b00, 2'b01, 1, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("addr_hs",   1, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(v("s_b0",      1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("s_b1",      1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("s_b2",      1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("s_b3",      1, 2'b00, 0, 1, 1, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("s_done",    1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    // contention right after reset: r0 then r1
    vecs.push_back(v("c_rst",     0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("c_idle",    1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("c_addr0",   1, 2'b11, 1, 0, 0, 2'b00, 2'b01, 1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(v("c_b0",      1, 2'b10, 0, 1, 0, 2'b11, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("c_b1",      1, 2'b10, 0, 1, 0, 2'b11, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("c_b2",      1, 2'b10, 0, 1, 0, 2'b11, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("c_b3",      1, 2'b10, 0, 1, 1, 2'b11, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("c_bubble",  1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("c_addr1",   1, 2'b10, 1, 0, 0, 2'b00, 2'b10, 1, 2'b10, 2'b00, 0, 0));
    vecs.push_back(v("c_r1b0",    1, 2'b00, 0, 1, 0, 2'b10, 2'b10, 0, 2'b00, 2'b10, 1, 0));
    vecs.push_back(v("c_r1b1",    1, 2'b00, 0, 1, 1, 2'b10, 2'b10, 0, 2'b00, 2'b10, 1, 0));
    vecs.push_back(v("c_done",    1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    // fairness: r0 keeps requesting, r1 joins mid-burst and is served next
    vecs.push_back(v("f_req0",    1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("f_addr0",   1, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(v("f_b0",      1, 2'b11, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("f_b1",      1, 2'b11, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("f_b2",      1, 2'b11, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("f_b3",      1, 2'b11, 0, 1, 1, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("f_bubble",  1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("f_addr1",   1, 2'b11, 1, 0, 0, 2'b00, 2'b10, 1, 2'b10, 2'b00, 0, 0));
    vecs.push_back(v("f_r1b0",    1, 2'b01, 0, 1, 0, 2'b10, 2'b10, 0, 2'b00, 2'b10, 1, 0));
    vecs.push_back(v("f_r1b1",    1, 2'b01, 0, 1, 1, 2'b10, 2'b10, 0, 2'b00, 2'b10, 1, 0));
    vecs.push_back(v("f_bubble2", 1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("f_addr0b",  1, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 2'b01, 2'b00, 0, 0));
    // backpressure: s_rready[0] low for 3 cycles mid-burst
    vecs.push_back(v("bp_b0",     1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("bp_hold1",  1, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0, 0));
    vecs.push_back(v("bp_hold2",  1, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0, 0));
    vecs.push_back(v("bp_hold3",  1, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0, 0));
    vecs.push_back(v("bp_b1",     1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("bp_b2",     1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("bp_b3",     1, 2'b00, 0, 1, 1, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("bp_done",   1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    // length error: r1 arlen=1 but rlast on the first beat
    vecs.push_back(v("le_req1",   1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("le_addr1",  1, 2'b10, 1, 0, 0, 2'b00, 2'b10, 1, 2'b10, 2'b00, 0, 0));
    vecs.push_back(v("le_beat",   1, 2'b00, 0, 1, 1, 2'b10, 2'b10, 0, 2'b00, 2'b10, 1, 0));
    vecs.push_back(v("le_set",    1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(v("le_hold",   1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(v("le_rst",    0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(v("le_clr",    1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    // reset mid-DATA after 2 of 4 beats
    vecs.push_back(v("rd_req0",   1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("rd_addr0",  1, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(v("rd_b0",     1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("rd_b1",     1, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("rd_rst",    0, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(v("rd_after",  1, 2'b00, 0, 1, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v("rd_after2", 1, 2'b00, 0, 1, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0, 0));
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    s_arid    = {8'hB1, 8'hA0};
    s_araddr  = {16'h0200, 16'h0010};
    s_arlen   = {8'd1, 8'd3};
    s_arvalid = 2'b00;
    s_rready  = 2'b00;
    m_arready = 1'b0;
    m_rid     = 8'h3C;
    m_rdata   = 32'h0;
    m_rlast   = 1'b0;
    m_rvalid  = 1'b0;
    fill_table();
    repeat (2) @(posedge clk);

    chk("m_arsize", 32'(m_arsize), 32'd2);
    chk("m_arburst", 32'(m_arburst), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n     = vecs[i].rst_n;
      s_arvalid = vecs[i].arv;
      m_arready = vecs[i].arr;
      m_rvalid  = vecs[i].rv;
      m_rlast   = vecs[i].rl;
      s_rready  = vecs[i].rr;
      m_rdata   = 32'h1000 + 32'(i);
      #1;
      chk({vecs[i].name, ".grant"},     32'(grant),     32'(vecs[i].e_grant));
      chk({vecs[i].name, ".m_arvalid"}, 32'(m_arvalid), 32'(vecs[i].e_marv));
      chk({vecs[i].name, ".s_arready"}, 32'(s_arready), 32'(vecs[i].e_sarr));
      chk({vecs[i].name, ".s_rvalid"},  32'(s_rvalid),  32'(vecs[i].e_srv));
      chk({vecs[i].name, ".m_rready"},  32'(m_rready),  32'(vecs[i].e_mrr));
      chk({vecs[i].name, ".len_err"},   32'(len_err),   32'(vecs[i].e_lerr));
      if (vecs[i].e_marv) begin
        chk({vecs[i].name, ".m_araddr"}, 32'(m_araddr),
            vecs[i].e_grant == 2'b01 ? 32'h0010 : 32'h0200);
        chk({vecs[i].name, ".m_arlen"}, 32'(m_arlen),
            vecs[i].e_grant == 2'b01 ? 32'd3 : 32'd1);
        chk({vecs[i].name, ".m_arid"}, 32'(m_arid),
            vecs[i].e_grant == 2'b01 ? 32'hA0 : 32'hB1);
      end
      if (vecs[i].e_srv != 2'b00) begin
        chk({vecs[i].name, ".s_rdata"}, s_rdata, 32'h1000 + 32'(i));
      end
    end

    // AR latency: r1 asserts arvalid from IDLE, m_arvalid exactly one cycle later.
    @(negedge clk);
    rst_n = 1'b1; s_arvalid = 2'b10; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    #1;
    chk("lat.c0_m_arvalid", 32'(m_arvalid), 32'd0);
    cyc = 0;
    while (!m_arvalid && cyc < 8) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("lat.cycles", 32'(cyc), 32'd1);
    chk("lat.m_araddr", 32'(m_araddr), 32'h0200);
    m_arready = 1'b1;
    #1;
    chk("lat.s_arready", 32'(s_arready), 32'b10);

    // R payload routing for r1's two-beat burst.
    @(negedge clk);
    s_arvalid = 2'b00; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 2'b10;
    m_rdata = 32'hDEADBEEF; m_rid = 8'h5A;
    #1;
    chk("rp.b0_s_rvalid", 32'(s_rvalid), 32'b10);
    chk("rp.b0_s_rdata", s_rdata, 32'hDEADBEEF);
    chk("rp.b0_s_rid", 32'(s_rid), 32'h5A);
    chk("rp.b0_s_rlast", 32'(s_rlast), 32'd0);
    @(negedge clk);
    m_rlast = 1'b1; m_rdata = 32'hCAFEF00D;
    #1;
    chk("rp.b1_s_rdata", s_rdata, 32'hCAFEF00D);
    chk("rp.b1_s_rlast", 32'(s_rlast), 32'd1);
    chk("rp.b1_m_rready", 32'(m_rready), 32'd1);
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    #1;
    chk("rp.end_grant", 32'(grant), 32'd0);
    chk("rp.end_len_err", 32'(len_err), 32'd0);
    chk("rp.end_s_rvalid", 32'(s_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
